// File: rtl/booth_sequencer.sv
// Iteration sequencer for a radix-2 Booth multiplier: drives load/add/sub/shift strobes for WIDTH iterations.
// Optional abort input/aborted output are built in when BOOTH_ABORT_EN is defined.
module booth_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       q_pair,
`ifdef BOOTH_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             load_regs,
  output logic             add_en,
  output logic             sub_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_r;

  // Sequencer state, iteration counter and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      iter_cnt  <= CNT_W'(0);
      load_regs <= 1'b0;
      shift_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BOOTH_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      load_regs <= 1'b0;
      shift_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BOOTH_ABORT_EN
      aborted   <= 1'b0;
      if (abort && ((state_r == LOAD) || (state_r == EVAL) || (state_r == SHIFT))) begin
        state_r  <= IDLE;
        iter_cnt <= CNT_W'(0);
        aborted  <= 1'b1;
      end else
`endif
      begin
        case (state_r)
          IDLE: begin
            if (start) begin
              state_r   <= LOAD;
              load_regs <= 1'b1;
              busy      <= 1'b1;
              iter_cnt  <= CNT_W'(WIDTH);
            end else begin
              state_r   <= IDLE;
            end
          end
          LOAD: begin
            state_r <= EVAL;
            busy    <= 1'b1;
          end
          EVAL: begin
            state_r  <= SHIFT;
            shift_en <= 1'b1;
            busy     <= 1'b1;
          end
          SHIFT: begin
            // Guarded decrement keeps the counter from wrapping below zero
            if (iter_cnt != CNT_W'(0)) begin
              iter_cnt <= iter_cnt - CNT_W'(1);
            end else begin
              iter_cnt <= CNT_W'(0);
            end
            if (iter_cnt <= CNT_W'(1)) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r <= EVAL;
              busy    <= 1'b1;
            end
          end
          DONE: begin
            state_r  <= IDLE;
            iter_cnt <= CNT_W'(0);
          end
          default: begin
            state_r  <= IDLE;
            iter_cnt <= CNT_W'(0);
          end
        endcase
      end
    end
  end

  // Booth recoding of {Q[0],Q[-1]}; only looked at while in EVAL so stale pairs never leak out
  always_comb begin
    add_en = 1'b0;
    sub_en = 1'b0;
    if (state_r == EVAL) begin
      case (q_pair)
        2'b01:   add_en = 1'b1;
        2'b10:   sub_en = 1'b1;
        default: begin
          add_en = 1'b0;
          sub_en = 1'b0;
        end
      endcase
    end else begin
      add_en = 1'b0;
      sub_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed, table-driven bench for booth_sequencer (WIDTH=8), with hand-written multi-cycle sequences.
module tb_booth_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] q_pair;
  logic       load_regs, add_en, sub_en, shift_en, busy, done;
  logic [3:0] iter_cnt;
`ifdef BOOTH_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks   = 0;
  int failures = 0;

  booth_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q_pair    (q_pair),
`ifdef BOOTH_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .load_regs (load_regs),
    .add_en    (add_en),
    .sub_en    (sub_en),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done),
    .iter_cnt  (iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       st;
    logic [1:0] qp;
    logic [5:0] exp;   // {load_regs, add_en, sub_en, shift_en, busy, done}
    logic       ic;    // compare iter_cnt on this row
    logic [3:0] it;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {load_regs, add_en, sub_en, shift_en, busy, done};
  endfunction

  // One start pulse with a fixed q_pair; reports cycle offsets relative to the start-sampling edge
  task automatic run_mult(input logic [1:0] qp, output int ld, output int sh, output int ad,
                          output int sb, output int dn, output int bz, output int both);
    ld = -1; sh = 0; ad = 0; sb = 0; dn = -1; bz = 0; both = 0;
    start  = 1'b1;
    q_pair = qp;
    for (int k = 1; k <= 22; k++) begin
      tick();
      start = 1'b0;
      if (load_regs && ld < 0) ld = k;
      if (done && dn < 0) dn = k;
      sh += int'(shift_en);
      ad += int'(add_en);
      sb += int'(sub_en);
      bz += int'(busy);
      both += int'(add_en && sub_en);
    end
  endtask

  vec_t tbl [21];

  initial begin
    int ld, sh, ad, sb, dn, bz, both;
    int nload, nshift, ndone, l0, l1, l2;
    bit seen3;

    //                rst   st    qp     exp        ic    it
    tbl[0]  = '{1'b0, 1'b1, 2'b00, 6'b000000, 1'b1, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 2'b00, 6'b100010, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 1'b0, 2'b01, 6'b010010, 1'b1, 4'd8};
    tbl[3]  = '{1'b0, 1'b0, 2'b01, 6'b000110, 1'b1, 4'd8};
    tbl[4]  = '{1'b0, 1'b0, 2'b10, 6'b001010, 1'b1, 4'd7};
    tbl[5]  = '{1'b0, 1'b1, 2'b10, 6'b000110, 1'b1, 4'd7};
    tbl[6]  = '{1'b0, 1'b0, 2'b11, 6'b000010, 1'b1, 4'd6};
    tbl[7]  = '{1'b0, 1'b0, 2'b10, 6'b000110, 1'b1, 4'd6};
    tbl[8]  = '{1'b0, 1'b0, 2'b00, 6'b000010, 1'b1, 4'd5};
    tbl[9]  = '{1'b0, 1'b0, 2'b01, 6'b000110, 1'b1, 4'd5};
    tbl[10] = '{1'b0, 1'b0, 2'b01, 6'b010010, 1'b1, 4'd4};
    tbl[11] = '{1'b0, 1'b0, 2'b10, 6'b000110, 1'b1, 4'd4};
    tbl[12] = '{1'b0, 1'b0, 2'b10, 6'b001010, 1'b1, 4'd3};
    tbl[13] = '{1'b0, 1'b0, 2'b01, 6'b000110, 1'b1, 4'd3};
    tbl[14] = '{1'b0, 1'b0, 2'b00, 6'b000010, 1'b1, 4'd2};
    tbl[15] = '{1'b0, 1'b0, 2'b10, 6'b000110, 1'b1, 4'd2};
    tbl[16] = '{1'b0, 1'b0, 2'b11, 6'b000010, 1'b1, 4'd1};
    tbl[17] = '{1'b0, 1'b0, 2'b01, 6'b000110, 1'b1, 4'd1};
    tbl[18] = '{1'b0, 1'b1, 2'b01, 6'b000001, 1'b1, 4'd0};
    tbl[19] = '{1'b0, 1'b0, 2'b00, 6'b000000, 1'b1, 4'd0};
    tbl[20] = '{1'b0, 1'b0, 2'b00, 6'b000000, 1'b1, 4'd0};

    reset  = 1'b1;
    start  = 1'b1;
    q_pair = 2'b00;
`ifdef BOOTH_ABORT_EN
    abort  = 1'b0;
`endif

    // Reset held two edges with start high
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_iter", 32'(iter_cnt), 32'h0);
    tick();
    chk("reset_start_ignored", 32'(outs()), 32'h0);

    // Cycle-by-cycle multiply with a mixed q_pair pattern
    for (int i = 0; i < 21; i++) begin
      reset  = tbl[i].rst;
      start  = tbl[i].st;
      q_pair = tbl[i].qp;
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
      if (tbl[i].ic) chk($sformatf("vec%0d_iter", i), 32'(iter_cnt), 32'(tbl[i].it));
      tick();
    end

    // q_pair=00 throughout: only shifts, done 18 cycles after the start edge
    run_mult(2'b00, ld, sh, ad, sb, dn, bz, both);
    chk("zero_load_at", 32'(ld), 32'd1);
    chk("zero_shifts", 32'(sh), 32'd8);
    chk("zero_add_sub", 32'(ad + sb), 32'd0);
    chk("zero_done_at", 32'(dn), 32'd18);
    chk("zero_busy_cycles", 32'(bz), 32'd17);

    // start held continuously: one load per 19 cycles
    nload = 0; ndone = 0; both = 0; l0 = -1; l1 = -1; l2 = -1;
    start = 1'b1;
    q_pair = 2'b01;
    for (int k = 1; k <= 57; k++) begin
      tick();
      q_pair = (k % 3 == 0) ? 2'b10 : 2'b01;
      if (load_regs) begin
        if (nload == 0) l0 = k;
        else if (nload == 1) l1 = k;
        else if (nload == 2) l2 = k;
        nload++;
      end
      ndone += int'(done);
      both  += int'(add_en && sub_en);
    end
    start = 1'b0;
    chk("held_load_count", 32'(nload), 32'd3);
    chk("held_load0", 32'(l0), 32'd1);
    chk("held_load1", 32'(l1), 32'd20);
    chk("held_load2", 32'(l2), 32'd39);
    chk("held_done_count", 32'(ndone), 32'd3);
    chk("held_add_sub_excl", 32'(both), 32'd0);
    tick();

    // Reset after the third shift, then a fresh multiply
    nshift = 0; seen3 = 1'b0;
    start = 1'b1;
    q_pair = 2'b00;
    for (int k = 1; k <= 30 && !seen3; k++) begin
      tick();
      start = 1'b0;
      nshift += int'(shift_en);
      if (nshift == 3) seen3 = 1'b1;
    end
    chk("rst_mid_third_shift_seen", 32'(seen3), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_outs", 32'(outs()), 32'h0);
    chk("rst_mid_iter", 32'(iter_cnt), 32'h0);
    ndone = 0; nload = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      ndone += int'(done);
      nload += int'(load_regs);
    end
    chk("rst_mid_no_done", 32'(ndone), 32'd0);
    chk("rst_mid_no_restart", 32'(nload), 32'd0);
    run_mult(2'b11, ld, sh, ad, sb, dn, bz, both);
    chk("after_rst_done_at", 32'(dn), 32'd18);
    chk("after_rst_shifts", 32'(sh), 32'd8);
    chk("after_rst_add_sub", 32'(ad + sb), 32'd0);

`ifdef BOOTH_ABORT_EN
    // Abort during the fourth EVAL
    begin
      int neval, nstrobe, nab;
      bit hit;
      neval = 0; hit = 1'b0; nstrobe = 0; nab = 0; ndone = 0;
      start = 1'b1;
      q_pair = 2'b01;
      for (int k = 1; k <= 30 && !hit; k++) begin
        tick();
        start = 1'b0;
        if (busy && !load_regs && !shift_en) neval++;
        if (neval == 4) hit = 1'b1;
      end
      chk("abort_eval4_seen", 32'(hit), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_pulse", 32'(aborted), 32'd1);
      chk("abort_iter", 32'(iter_cnt), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 20; k++) begin
        tick();
        nstrobe += int'(add_en) + int'(sub_en) + int'(shift_en);
        nab     += int'(aborted);
        ndone   += int'(done);
      end
      chk("abort_no_strobes", 32'(nstrobe), 32'd0);
      chk("abort_single_pulse", 32'(nab), 32'd0);
      chk("abort_no_done", 32'(ndone), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
